// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with a halt-time sweep of the array onto a dump port.
// Define DMEM_ALIGN_CHECK_EN to flag odd byte addresses with err and suppress their writes.
module dmem_responder #(
    parameter int MEM_AW  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        createdump,
    output logic [15:0] data_out,
    output logic        done,
    output logic        stall,
    output logic        err,
    output logic        dump_valid,
    output logic [15:0] dump_addr,
    output logic [15:0] dump_data,
    output logic        dump_done,
    output logic [1:0]  dbg_state_o
);

    // Handshake: enable is a valid that the initiator holds until done; stall is the
    // inverse of ready, and done is a one-cycle completion pulse for the accepted request.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_DUMP   = 2'd2,
        S_HALTED = 2'd3
    } state_e;

    localparam int              WORDS     = 1 << MEM_AW;
    localparam logic [MEM_AW-1:0] FIRST_IDX = '0;
    localparam logic [MEM_AW-1:0] LAST_IDX  = '1;
    localparam logic [3:0]      CNT_INIT  = 4'(LATENCY - 1);

    state_e              state_q;
    logic [3:0]          cnt_q;
    logic                wr_q;
    logic [MEM_AW-1:0]   word_q;
    logic [15:0]         wdata_q;
    logic                mis_q;
    logic [MEM_AW-1:0]   idx_q;
    logic                done_q;
    logic                err_q;
    logic [15:0]         rdata_q;
    logic                dv_q;
    logic [15:0]         daddr_q;
    logic [15:0]         ddata_q;
    logic                ddone_q;
    logic [15:0]         mem_q [WORDS];

    logic [MEM_AW-1:0]   req_word_d;
    logic                req_mis_d;
    logic [MEM_AW-1:0]   idx_d;
    logic                stall_d;
    logic                unused_addr;

    assign req_word_d  = addr[MEM_AW:1];
    assign idx_d       = idx_q + 1'b1;
    assign unused_addr = ^{addr[15:MEM_AW+1], addr[0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign req_mis_d = addr[0];
`else
    assign req_mis_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            word_q  <= '0;
            wdata_q <= 16'h0;
            mis_q   <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 16'h0;
            dv_q    <= 1'b0;
            daddr_q <= 16'h0;
            ddata_q <= 16'h0;
            ddone_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (createdump) begin
                        state_q <= S_DUMP;
                        idx_q   <= FIRST_IDX;
                        dv_q    <= 1'b1;
                        daddr_q <= 16'h0;
                        ddata_q <= mem_q[FIRST_IDX];
                    end else if (enable) begin
                        state_q <= S_WAIT;
                        cnt_q   <= CNT_INIT;
                        wr_q    <= wr;
                        word_q  <= req_word_d;
                        wdata_q <= data_in;
                        mis_q   <= req_mis_d;
                        // A one-cycle latency means the very next cycle is the done cycle.
                        if (LATENCY == 1) begin
                            done_q  <= 1'b1;
                            err_q   <= req_mis_d;
                            rdata_q <= (wr || req_mis_d) ? 16'h0 : mem_q[req_word_d];
                        end
                    end
                end
                S_WAIT: begin
                    if (done_q) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        rdata_q <= 16'h0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            done_q  <= 1'b1;
                            err_q   <= mis_q;
                            rdata_q <= (wr_q || mis_q) ? 16'h0 : mem_q[word_q];
                        end
                    end
                end
                S_DUMP: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_HALTED;
                        dv_q    <= 1'b0;
                        daddr_q <= 16'h0;
                        ddata_q <= 16'h0;
                        ddone_q <= 1'b1;
                    end else begin
                        idx_q   <= idx_d;
                        daddr_q <= 16'({idx_d, 1'b0});
                        ddata_q <= mem_q[idx_d];
                    end
                end
                S_HALTED: begin
                    state_q <= S_HALTED;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The write lands at the edge closing the done cycle; a reset at that edge discards it.
    always_ff @(posedge clk) begin
        if (rst && state_q == S_WAIT && done_q && wr_q && !mis_q) begin
            mem_q[word_q] <= wdata_q;
        end
    end

    always_comb begin
        stall_d = 1'b0;
        case (state_q)
            S_IDLE:   stall_d = enable | createdump;
            S_WAIT:   stall_d = ~done_q;
            S_DUMP:   stall_d = 1'b1;
            S_HALTED: stall_d = 1'b1;
            default:  stall_d = 1'b0;
        endcase
    end

    assign stall       = rst & stall_d;
    assign done        = rst & done_q;
    assign err         = rst & err_q;
    assign data_out    = rst ? rdata_q : 16'h0;
    assign dump_valid  = rst & dv_q;
    assign dump_addr   = rst ? daddr_q : 16'h0;
    assign dump_data   = rst ? ddata_q : 16'h0;
    assign dump_done   = rst & ddone_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: two instances (short array / latency 2, full array / latency 1)
// checked against a word-array reference model, plus directed reset, wrap and dump scenarios.
module tb_dmem_responder;

    localparam int AW0  = 4;
    localparam int LAT0 = 2;
    localparam int AW1  = 10;
    localparam int LAT1 = 1;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en      [2];
    logic        wr_s    [2];
    logic        cd      [2];
    logic [15:0] ad      [2];
    logic [15:0] di      [2];
    logic [15:0] dout    [2];
    logic [15:0] daddr   [2];
    logic [15:0] ddata   [2];
    logic        done_s  [2];
    logic        stall_s [2];
    logic        err_s   [2];
    logic        dv      [2];
    logic        ddone   [2];
    logic [1:0]  st      [2];

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] model [2][1024];
    logic [15:0] exp_q [$];
    int          lat   [2] = '{LAT0, LAT1};
    int          mask  [2] = '{(1 << AW0) - 1, (1 << AW1) - 1};

    dmem_responder #(.MEM_AW(AW0), .LATENCY(LAT0)) u_dut0 (
        .clk(clk), .rst(rst), .enable(en[0]), .wr(wr_s[0]), .addr(ad[0]), .data_in(di[0]),
        .createdump(cd[0]), .data_out(dout[0]), .done(done_s[0]), .stall(stall_s[0]),
        .err(err_s[0]), .dump_valid(dv[0]), .dump_addr(daddr[0]), .dump_data(ddata[0]),
        .dump_done(ddone[0]), .dbg_state_o(st[0])
    );

    dmem_responder #(.MEM_AW(AW1), .LATENCY(LAT1)) u_dut1 (
        .clk(clk), .rst(rst), .enable(en[1]), .wr(wr_s[1]), .addr(ad[1]), .data_in(di[1]),
        .createdump(cd[1]), .data_out(dout[1]), .done(done_s[1]), .stall(stall_s[1]),
        .err(err_s[1]), .dump_valid(dv[1]), .dump_addr(daddr[1]), .dump_data(ddata[1]),
        .dump_done(ddone[1]), .dbg_state_o(st[1])
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // One full request on instance k; entered and left just after a rising edge, in an idle cycle.
    task automatic do_req(input int k, input logic w, input logic [15:0] a, input logic [15:0] d);
        int          cyc;
        int          widx;
        logic        mis;
        logic [15:0] exp_d;
        widx = (int'(a) >> 1) & mask[k];
        mis  = ALIGN && a[0];
        en[k] = 1'b1; wr_s[k] = w; ad[k] = a; di[k] = d;
        #1;
        check("accept_stall", 16'(stall_s[k]), 16'd1);
        @(posedge clk); #1;
        cyc = 1;
        while (done_s[k] !== 1'b1 && cyc < 40) begin
            check("wait_stall", 16'(stall_s[k]), 16'd1);
            check("wait_dout", dout[k], 16'h0);
            wr_s[k] = 1'($urandom);
            ad[k]   = 16'($urandom);
            di[k]   = 16'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 16'(cyc), 16'(lat[k]));
        check("done", 16'(done_s[k]), 16'd1);
        check("done_stall", 16'(stall_s[k]), 16'd0);
        check("err", 16'(err_s[k]), 16'(mis));
        exp_d = (w || mis) ? 16'h0 : model[k][widx];
        check(w ? "wr_dout" : "rd_dout", dout[k], exp_d);
        if (w && !mis) model[k][widx] = d;
        @(posedge clk); #1;
        en[k] = 1'b0;
        check("idle_done", 16'(done_s[k]), 16'd0);
        check("idle_dout", dout[k], 16'h0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            en[k] = 1'b0; wr_s[k] = 1'b0; cd[k] = 1'b0; ad[k] = 16'h0; di[k] = 16'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_done", 16'(done_s[k]), 16'd0);
            check("rst_stall", 16'(stall_s[k]), 16'd0);
            check("rst_dump_valid", 16'(dv[k]), 16'd0);
            check("rst_dump_done", 16'(ddone[k]), 16'd0);
            check("rst_dout", dout[k], 16'h0);
            check("rst_err", 16'(err_s[k]), 16'd0);
            check("rst_state", 16'(st[k]), 16'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;

        // Give every word a known value so later reads have defined expectations.
        for (int k = 0; k < 2; k++)
            for (int w = 0; w <= mask[k]; w++)
                do_req(k, 1'b1, 16'(w * 2), 16'($urandom));

        do_req(0, 1'b1, 16'h0010, 16'hBEEF);
        do_req(0, 1'b0, 16'h0010, 16'h0);
        do_req(1, 1'b1, 16'h0000, 16'h1111);
        do_req(1, 1'b1, 16'h0002, 16'h2222);
        do_req(1, 1'b0, 16'h0000, 16'h0);
        do_req(1, 1'b0, 16'h0002, 16'h0);
        do_req(1, 1'b1, 16'h0804, 16'h5A5A);
        do_req(1, 1'b0, 16'h0004, 16'h0);
        do_req(0, 1'b1, 16'h0024, 16'h3C3C);
        do_req(0, 1'b0, 16'h0004, 16'h0);
`ifdef DMEM_ALIGN_CHECK_EN
        do_req(0, 1'b1, 16'h0011, 16'hDEAD);
        do_req(0, 1'b0, 16'h0010, 16'h0);
`endif

        for (int i = 0; i < 300; i++)
            do_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));

        // Reset while a latency-2 write is still counting down.
        en[0] = 1'b1; wr_s[0] = 1'b1; ad[0] = 16'h000A; di[0] = ~model[0][5];
        @(posedge clk); #1;
        check("inflight_stall", 16'(stall_s[0]), 16'd1);
        rst = 1'b0;
        #1;
        check("inflight_rst_stall", 16'(stall_s[0]), 16'd0);
        @(posedge clk); #1;
        check("inflight_rst_done", 16'(done_s[0]), 16'd0);
        check("inflight_rst_state", 16'(st[0]), 16'd0);
        en[0] = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        do_req(0, 1'b0, 16'h000A, 16'h0);

        // Reset landing in the done cycle of a latency-1 write.
        en[1] = 1'b1; wr_s[1] = 1'b1; ad[1] = 16'h0100; di[1] = ~model[1][128];
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("donecyc_rst_done", 16'(done_s[1]), 16'd0);
        @(posedge clk); #1;
        en[1] = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        do_req(1, 1'b0, 16'h0100, 16'h0);

        // Dump with a simultaneous request that must be dropped.
        en[0] = 1'b1; wr_s[0] = 1'b1; ad[0] = 16'h0006; di[0] = ~model[0][3]; cd[0] = 1'b1;
        #1;
        check("dump_req_stall", 16'(stall_s[0]), 16'd1);
        @(posedge clk); #1;
        for (int w = 0; w < (1 << AW0); w++) exp_q.push_back(model[0][w]);
        for (int i = 0; i < (1 << AW0); i++) begin
            check("dump_valid", 16'(dv[0]), 16'd1);
            check("dump_addr", daddr[0], 16'(i * 2));
            check("dump_data", ddata[0], exp_q.pop_front());
            check("dump_stall", 16'(stall_s[0]), 16'd1);
            check("dump_no_done", 16'(done_s[0]), 16'd0);
            @(posedge clk); #1;
        end
        check("halt_valid", 16'(dv[0]), 16'd0);
        check("halt_dump_done", 16'(ddone[0]), 16'd1);
        check("halt_stall", 16'(stall_s[0]), 16'd1);
        cd[0] = 1'b0; en[0] = 1'b1; wr_s[0] = 1'b1; ad[0] = 16'h0000; di[0] = ~model[0][0];
        repeat (6) begin
            @(posedge clk); #1;
            check("halt_no_done", 16'(done_s[0]), 16'd0);
            check("halt_dump_done_hold", 16'(ddone[0]), 16'd1);
            check("halt_stall_hold", 16'(stall_s[0]), 16'd1);
        end
        en[0] = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        check("post_halt_rst_dump_done", 16'(ddone[0]), 16'd0);
        check("post_halt_rst_state", 16'(st[0]), 16'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        do_req(0, 1'b0, 16'h0006, 16'h0);
        do_req(0, 1'b0, 16'h0000, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Multi-cycle data-memory responder that sits on the memory side of the MA stage's data-memory request interface.
- Accepts one read or write request at a time and completes it after a fixed latency.
- Returns read data with a done pulse and holds stall until completion.
- On createdump (halt) sweeps the whole array out on a dump port, then freezes.
- Replaces the single-cycle memory so the pipeline can be exercised against realistic memory latency.

Parameters:
MEM_AW, 10, log2 of word count; array is 2^MEM_AW 16-bit words.
LATENCY, 2, cycles from request acceptance to done; legal range 1..15.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-low reset
enable  input  1  request valid (read or write); held stable by initiator until done
wr  input  1  1=write, 0=read; qualified by enable
addr  input  16  byte address; word index = addr[MEM_AW:1], higher bits ignored (wrap)
data_in  input  16  write data
createdump  input  1  halt: dump array, then freeze
data_out  output  16  read data, valid only while done=1, else 0
done  output  1  completion pulse for current request
stall  output  1  initiator must hold request
err  output  1  misaligned-access flag (see Optional Feature)
dump_valid  output  1  dump word valid this cycle
dump_addr  output  16  byte address of dump word
dump_data  output  16  dump word
dump_done  output  1  dump complete; held high in HALTED

Behaviour:
- Clock and reset: all state updates on posedge clk; rst is synchronous and active-low.
- Reset (rst=0 at an edge): state=IDLE, cnt=0, latched request cleared, dump idx=0.
- Outputs during and after reset: done=0, err=0, dump_valid=0, dump_done=0, data_out=0, stall=0.
- Array contents are not reset.
- Reset mid-request aborts it; a pending write is never committed.
- States: IDLE, WAIT, DUMP, HALTED.
- IDLE:
  - createdump=1 -> DUMP, idx=0; takes priority over enable; a simultaneous request is dropped.
  - Else enable=1 -> latch addr/wr/data_in, cnt=LATENCY-1, go to WAIT.
  - stall = enable | createdump (combinational).
- WAIT, cnt!=0: cnt decrements; stall=1.
- WAIT, cnt==0 (the done cycle):
  - done=1, stall=0.
  - Read: data_out = array[latched word].
  - Write: array[latched word] <= latched data at this edge; data_out=0.
  - Next state IDLE.
- Latency: request accepted at edge T completes with done in cycle T+LATENCY.
- Back-to-back requests: a request held in the cycle after done is accepted as a new request.
- Request inputs are sampled only at acceptance; later changes during WAIT are ignored.
- createdump seen while in WAIT is ignored; it is taken when back in IDLE if still asserted.
- DUMP:
  - Each cycle: dump_valid=1, dump_addr={idx,1'b0} zero-extended to 16 bits, dump_data=array[idx].
  - idx increments each cycle.
  - After idx=2^MEM_AW-1 -> HALTED; exactly 2^MEM_AW valid cycles.
  - stall=1.
- HALTED: dump_done=1, stall=1, all requests ignored, array frozen; exit only by reset.

Optional Feature:
Macro DMEM_ALIGN_CHECK_EN.
- Defined: a request with addr[0]=1 still takes LATENCY cycles. Its done cycle asserts err=1 and done=1 with data_out=0, and any write is suppressed (array unchanged). err=0 at all other times.
- Not defined: addr[0] is ignored, the access uses addr[MEM_AW:1], and err is tied 0.

Test Plan:
- Reset for 2 cycles -> done=0, stall=0, dump_valid=0, dump_done=0, data_out=0.
- LATENCY=2: write 0xBEEF @0x0010 accepted at edge T -> stall high in cycles T, T+1; done=1 at T+2; read @0x0010 -> done 2 cycles after accept with data_out=0xBEEF.
- LATENCY=1, back-to-back writes @0x0000=0x1111 and @0x0002=0x2222, then reads -> each done one cycle after accept; data 0x1111, 0x2222.
- Address wrap: MEM_AW=10, write 0x5A5A @0x0804, read @0x0004 -> 0x5A5A.
- Write in flight, rst=0 before done, then read that address -> old contents; no done during reset.
- MEM_AW=4, createdump with enable=1 in IDLE -> request dropped; 16 dump_valid cycles with dump_addr 0x0000..0x001E; then dump_done=1, stall=1; later enable gives no done.
- DMEM_ALIGN_CHECK_EN: write @0x0011 -> err=1 with done; word @0x0010 unchanged.
